// File: rtl/apple1_io_pkg.sv
// Shared constants and types for the Apple-1 terminal I/O controller.
// Register offsets, default window base and display-state encoding.
package apple1_io_pkg;

  localparam logic [1:0]  OFF_KBD      = 2'd0;
  localparam logic [1:0]  OFF_KBDCR    = 2'd1;
  localparam logic [1:0]  OFF_DSP      = 2'd2;
  localparam logic [1:0]  OFF_DSPCR    = 2'd3;

  localparam logic [6:0]  ASCII_CR     = 7'h0D;
  localparam logic [15:0] DEFAULT_BASE = 16'hD010;

  typedef enum logic {
    DSP_IDLE = 1'b0,
    DSP_BUSY = 1'b1
  } dsp_state_t;

  // Map 'a'..'z' onto 'A'..'Z'; everything else passes through.
  function automatic logic [6:0] to_upper(input logic [6:0] c);
    logic [6:0] r;
    r = c;
    if (c >= 7'h61 && c <= 7'h7A) r = c - 7'h20;
    return r;
  endfunction

endpackage

// File: rtl/apple1_kbd_fifo.sv
// Synchronous keyboard FIFO with show-ahead head output.
// Push is ignored when full, pop is ignored when empty.
module apple1_kbd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apple1_term_ctrl.sv
// Apple-1 KBD/KBDCR/DSP/DSPCR register window bridging the 6502 bus
// to valid/ready keyboard source and display sink.
module apple1_term_ctrl
  import apple1_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = DEFAULT_BASE,
  parameter int unsigned KBD_DEPTH = 4,
  parameter bit          UPCASE    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] address_bus,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        io_sel,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        kbd_ready,
  output logic        dsp_valid,
  output logic [6:0]  dsp_data,
  input  logic        dsp_ready,
  output logic        dsp_overrun
);

  logic [1:0] reg_off;
  logic       sel_rd;
  logic       sel_wr;
  logic       kbd_rd;
  logic       kbd_rd_q;
  logic       kbd_pop;
  logic       kbd_push;
  logic [6:0] kbd_char;
  logic       kbd_full;
  logic       kbd_empty;
  logic [6:0] kbd_head;
  logic [6:0] last_popped;
  logic [6:0] cr_k;
  logic [6:0] cr_d;
  logic       dsp_wr;
  logic       dspcr_wr;
  logic       kbdcr_wr;
  logic       busy;
  dsp_state_t state_q;
  dsp_state_t state_d;
  logic       unused_bits;

  assign unused_bits = kbd_data[7] ^ cpu_wdata[7];

  assign io_sel   = (address_bus[15:2] == BASE_ADDR[15:2]);
  assign reg_off  = address_bus[1:0];
  assign sel_rd   = io_sel && mem_read;
  assign sel_wr   = io_sel && mem_write;
  assign kbdcr_wr = sel_wr && (reg_off == OFF_KBDCR);
  assign dsp_wr   = sel_wr && (reg_off == OFF_DSP);
  assign dspcr_wr = sel_wr && (reg_off == OFF_DSPCR);

  // Keyboard side: pop only on the first cycle of a KBD read.
  assign kbd_rd    = sel_rd && (reg_off == OFF_KBD);
  assign kbd_pop   = kbd_rd && !kbd_rd_q;
  assign kbd_ready = !kbd_full;
  assign kbd_push  = kbd_valid && kbd_ready;
  assign kbd_char  = UPCASE ? to_upper(kbd_data[6:0]) : kbd_data[6:0];

  apple1_kbd_fifo #(
    .DEPTH (KBD_DEPTH),
    .WIDTH (7)
  ) u_kbd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (kbd_push),
    .push_data (kbd_char),
    .pop       (kbd_pop),
    .full      (kbd_full),
    .empty     (kbd_empty),
    .head      (kbd_head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kbd_rd_q    <= 1'b0;
      last_popped <= '0;
    end else begin
      kbd_rd_q <= kbd_rd;
      if (kbd_pop && !kbd_empty) last_popped <= kbd_head;
    end
  end

  // Control registers; a DSPCR write also acknowledges an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cr_k        <= '0;
      cr_d        <= '0;
      dsp_overrun <= 1'b0;
    end else begin
      if (kbdcr_wr) cr_k <= cpu_wdata[6:0];
      if (dspcr_wr) cr_d <= cpu_wdata[6:0];
      if (dsp_wr && (state_q == DSP_BUSY)) dsp_overrun <= 1'b1;
      else if (dspcr_wr)                   dsp_overrun <= 1'b0;
    end
  end

  // Display FSM: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= DSP_IDLE;
    else          state_q <= state_d;
  end

  // Display FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DSP_IDLE: if (dsp_wr)    state_d = DSP_BUSY;
      DSP_BUSY: if (dsp_ready) state_d = DSP_IDLE;
      default:                 state_d = DSP_IDLE;
    endcase
  end

  // Display FSM: outputs decoded from the registered state.
  always_comb begin
    busy      = 1'b0;
    dsp_valid = 1'b0;
    if (state_q == DSP_BUSY) begin
      busy      = 1'b1;
      dsp_valid = 1'b1;
    end
  end

  // Character is only captured from IDLE; writes while BUSY are overruns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          dsp_data <= '0;
    else if (dsp_wr && state_q == DSP_IDLE) dsp_data <= cpu_wdata[6:0];
  end

  always_comb begin
    cpu_rdata = 8'h00;
    if (sel_rd) begin
      case (reg_off)
        OFF_KBD:   cpu_rdata = kbd_empty ? {1'b0, last_popped} : {1'b1, kbd_head};
        OFF_KBDCR: cpu_rdata = {!kbd_empty, cr_k};
        OFF_DSP:   cpu_rdata = {busy, dsp_data};
        OFF_DSPCR: cpu_rdata = {dsp_overrun, cr_d};
        default:   cpu_rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_apple1_term_ctrl.sv
// Directed self-checking bench for apple1_term_ctrl.
module tb_apple1_term_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] address_bus;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        mem_read;
  logic        mem_write;
  logic        io_sel;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic        kbd_ready;
  logic        dsp_valid;
  logic [6:0]  dsp_data;
  logic        dsp_ready;
  logic        dsp_overrun;

  int tests = 0;
  int fails = 0;

  apple1_term_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address_bus (address_bus),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .io_sel      (io_sel),
    .kbd_valid   (kbd_valid),
    .kbd_data    (kbd_data),
    .kbd_ready   (kbd_ready),
    .dsp_valid   (dsp_valid),
    .dsp_data    (dsp_data),
    .dsp_ready   (dsp_ready),
    .dsp_overrun (dsp_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle read followed by an idle cycle so the next read pops again.
  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
    address_bus = a;
    mem_read = 1'b1;
    #1;
    tests++;
    if (cpu_rdata !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, cpu_rdata, exp);
    end
    tick();
    mem_read = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address_bus = a;
    cpu_wdata = d;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    kbd_valid = 1'b1;
    kbd_data = d;
    tick();
    kbd_valid = 1'b0;
  endtask

  task automatic chk1(input logic got, input logic exp, input string name);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic chk7(input logic [6:0] got, input logic [6:0] exp, input string name);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic chk8(input logic [7:0] got, input logic [7:0] exp, input string name);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rd(16'hD011, 8'h00, "reset_kbdcr");
    rd(16'hD012, 8'h00, "reset_dsp");
    rd(16'hD013, 8'h00, "reset_dspcr");
    chk1(kbd_ready, 1'b1, "reset_kbd_ready");
    chk1(dsp_valid, 1'b0, "reset_dsp_valid");
    address_bus = 16'hD014;
    mem_read = 1'b1;
    #1;
    chk1(io_sel, 1'b0, "outside_io_sel");
    chk8(cpu_rdata, 8'h00, "outside_rdata");
    address_bus = 16'hD013;
    #1;
    chk1(io_sel, 1'b1, "inside_io_sel");
    mem_read = 1'b0;
    #1;
    chk8(cpu_rdata, 8'h00, "no_read_rdata");
    tick();
  endtask

  task automatic test_kbd_single();
    push(8'h45);
    rd(16'hD011, 8'h80, "kbd_avail");
    rd(16'hD010, 8'hC5, "kbd_read_E");
    rd(16'hD011, 8'h00, "kbd_empty_after");
    rd(16'hD010, 8'h45, "kbd_last_popped");
    // Held read: only the first cycle pops.
    push(8'h41);
    push(8'h42);
    address_bus = 16'hD010;
    mem_read = 1'b1;
    #1;
    chk8(cpu_rdata, 8'hC1, "hold_c1");
    tick();
    chk8(cpu_rdata, 8'hC2, "hold_c2");
    tick();
    chk8(cpu_rdata, 8'hC2, "hold_c3");
    tick();
    mem_read = 1'b0;
    tick();
    rd(16'hD011, 8'h80, "hold_one_left");
    rd(16'hD010, 8'hC2, "hold_read_B");
    rd(16'hD011, 8'h00, "hold_drained");
  endtask

  task automatic test_kbd_full();
    push(8'h45);
    push(8'h30);
    push(8'h30);
    push(8'h30);
    chk1(kbd_ready, 1'b0, "full_ready_low");
    kbd_valid = 1'b1;
    kbd_data = 8'h52;
    tick();
    chk1(kbd_ready, 1'b0, "full_still_low");
    address_bus = 16'hD010;
    mem_read = 1'b1;
    #1;
    chk8(cpu_rdata, 8'hC5, "full_rd0");
    tick();
    mem_read = 1'b0;
    #1;
    chk1(kbd_ready, 1'b1, "full_ready_back");
    tick();
    kbd_valid = 1'b0;
    chk1(kbd_ready, 1'b0, "full_refilled");
    rd(16'hD010, 8'hB0, "full_rd1");
    rd(16'hD010, 8'hB0, "full_rd2");
    rd(16'hD010, 8'hB0, "full_rd3");
    rd(16'hD010, 8'hD2, "full_rd4");
    rd(16'hD011, 8'h00, "full_drained");
  endtask

  task automatic test_kbd_concurrent();
    // Empty FIFO: read and push together; read sees empty, key retained.
    kbd_valid = 1'b1;
    kbd_data = 8'h33;
    address_bus = 16'hD010;
    mem_read = 1'b1;
    #1;
    chk8(cpu_rdata, 8'h52, "empty_push_read");
    tick();
    kbd_valid = 1'b0;
    mem_read = 1'b0;
    tick();
    rd(16'hD011, 8'h80, "empty_push_kept");
    // Non-empty: push and pop in the same cycle.
    kbd_valid = 1'b1;
    kbd_data = 8'h34;
    address_bus = 16'hD010;
    mem_read = 1'b1;
    #1;
    chk8(cpu_rdata, 8'hB3, "pushpop_read");
    tick();
    kbd_valid = 1'b0;
    mem_read = 1'b0;
    tick();
    rd(16'hD011, 8'h80, "pushpop_count");
    rd(16'hD010, 8'hB4, "pushpop_next");
    rd(16'hD011, 8'h00, "pushpop_empty");
    wr(16'hD011, 8'hA7);
    rd(16'hD011, 8'h27, "kbdcr_write");
    wr(16'hD010, 8'hFF);
    rd(16'hD011, 8'h27, "kbd_write_ignored");
  endtask

  task automatic test_display();
    dsp_ready = 1'b0;
    wr(16'hD012, 8'h8D);
    chk1(dsp_valid, 1'b1, "dsp_valid_set");
    chk7(dsp_data, 7'h0D, "dsp_data_cr");
    rd(16'hD012, 8'h8D, "dsp_busy_read");
    dsp_ready = 1'b1;
    tick();
    dsp_ready = 1'b0;
    chk1(dsp_valid, 1'b0, "dsp_valid_clr");
    rd(16'hD012, 8'h0D, "dsp_idle_read");
  endtask

  task automatic test_overrun();
    wr(16'hD012, 8'h45);
    chk7(dsp_data, 7'h45, "ovr_first");
    wr(16'hD012, 8'hB0);
    chk7(dsp_data, 7'h45, "ovr_data_held");
    chk1(dsp_overrun, 1'b1, "ovr_flag");
    rd(16'hD013, 8'h80, "ovr_dspcr");
    wr(16'hD013, 8'hA7);
    rd(16'hD013, 8'h27, "ovr_cleared");
    // Write coinciding with the handshake is still an overrun.
    address_bus = 16'hD012;
    cpu_wdata = 8'h31;
    mem_write = 1'b1;
    dsp_ready = 1'b1;
    tick();
    mem_write = 1'b0;
    dsp_ready = 1'b0;
    chk1(dsp_valid, 1'b0, "ovr_hs_idle");
    chk7(dsp_data, 7'h45, "ovr_hs_data");
    chk1(dsp_overrun, 1'b1, "ovr_hs_flag");
    wr(16'hD013, 8'h00);
    chk1(dsp_overrun, 1'b0, "ovr_hs_clear");
  endtask

  task automatic test_upcase_reset();
    push(8'h65);
    rd(16'hD010, 8'hC5, "upcase_e");
    push(8'h7B);
    rd(16'hD010, 8'hFB, "no_upcase_brace");
    push(8'h41);
    push(8'h42);
    wr(16'hD012, 8'h48);
    chk1(dsp_valid, 1'b1, "pre_reset_valid");
    reset_n = 1'b0;
    address_bus = 16'hD011;
    mem_read = 1'b1;
    #1;
    chk8(cpu_rdata, 8'h00, "async_reset_kbdcr");
    chk1(dsp_valid, 1'b0, "async_reset_valid");
    chk7(dsp_data, 7'h00, "async_reset_data");
    mem_read = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    rd(16'hD011, 8'h00, "post_reset_empty");
  endtask

  initial begin
    reset_n = 1'b0;
    address_bus = 16'h0000;
    cpu_wdata = 8'h00;
    mem_read = 1'b0;
    mem_write = 1'b0;
    kbd_valid = 1'b0;
    kbd_data = 8'h00;
    dsp_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_kbd_single();
    test_kbd_full();
    test_kbd_concurrent();
    test_display();
    test_overrun();
    test_upcase_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apple1_term_ctrl.md
Name: apple1_term_ctrl

Overview:
Memory-mapped Apple-1 terminal I/O controller that replaces the PIA keyboard/display registers at $D010–$D013 on the 6502 CPU bus.
- Keyboard side: buffers incoming characters from a valid/ready terminal source and presents them to WozMon through KBD/KBDCR with the Apple-1 strobe semantics.
- Display side: holds DSP busy while a written character is handed off to a valid/ready terminal sink.
- Sits beside the memory interface; the top level muxes cpu_rdata in when io_sel is high.

Parameters:
BASE_ADDR, 16'hD010, base of the 4-register window; bits [1:0] must be 0.
KBD_DEPTH, 4, keyboard FIFO entries; power of two, minimum 2.
UPCASE, 1, when 1, ASCII 'a'–'z' are converted to upper case on push.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address_bus  in  16  CPU address
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  read data, valid in the same cycle as mem_read
mem_read  in  1  CPU read strobe
mem_write  in  1  CPU write strobe
io_sel  out  1  address_bus[15:2] == BASE_ADDR[15:2]
kbd_valid  in  1  terminal key available
kbd_data  in  8  terminal key code; bit 7 is ignored
kbd_ready  out  1  controller accepts a key
dsp_valid  out  1  character pending for terminal
dsp_data  out  7  pending character, 7-bit ASCII
dsp_ready  in  1  terminal accepts the character
dsp_overrun  out  1  sticky flag: DSP was written while busy

Behaviour:
Clock and reset
- One clock domain, clk. reset_n is asynchronous, active-low.
- Reset values: FIFO empty; kbd_ready=1; dsp_valid=0; dsp_data=0; busy=0; dsp_overrun=0; KBDCR=0; DSPCR=0; read-edge tracker cleared.
- Reset asserted mid-transfer discards any queued keys and any pending display character.

Register map (offset from BASE_ADDR)
- +0 KBD: read returns {1, head[6:0]} when the FIFO is non-empty, else {0, last_popped[6:0]}. Writes are ignored.
- +1 KBDCR: read returns {!empty, cr_k[6:0]}. Write stores cpu_wdata[6:0] into cr_k.
- +2 DSP: read returns {busy, dsp_data}. Write behaviour is defined under Display path.
- +3 DSPCR: read returns {dsp_overrun, cr_d[6:0]}. Write stores cr_d and clears dsp_overrun.

Read path
- cpu_rdata is combinational from the current state.
- cpu_rdata = 8'h00 when io_sel=0 or mem_read=0.

Keyboard path
- kbd_ready = !full (combinational).
- Push on kbd_valid && kbd_ready. Stored value is kbd_data[6:0], upcased when UPCASE=1.
- Pop once per access: on the first cycle of mem_read && KBD selected (rising edge of that qualifier). A multi-cycle read pops only once.
- Pop on an empty FIFO has no effect.
- Push and pop in the same cycle while non-empty: both take effect; count is unchanged.
- Full FIFO with a same-cycle pop: the push is not accepted, because kbd_ready was already low. kbd_ready rises the next cycle.
- Empty FIFO with a same-cycle push and read: the read returns bit7=0 and the pushed key is retained.
- Pointers wrap modulo KBD_DEPTH; count width is clog2(KBD_DEPTH)+1.

Display path (two states, IDLE and BUSY)
- IDLE: a write to DSP latches dsp_data=cpu_wdata[6:0], sets busy=1 and dsp_valid=1, and moves to BUSY on the next edge.
- BUSY: dsp_valid && dsp_ready returns to IDLE next cycle (busy=0, dsp_valid=0). dsp_data is held until the next accepted write.
- A DSP write while BUSY is dropped, sets dsp_overrun, and leaves dsp_data unchanged.
- If a DSP write and a handshake occur in the same cycle while BUSY, the write is still treated as an overrun.
- Latency: from CPU write to dsp_valid is 1 cycle. WozMon's BIT DSP / BMI poll loop relies on busy.

Decomposition:
- Package apple1_io_pkg holds:
  - register offset constants: OFF_KBD=0, OFF_KBDCR=1, OFF_DSP=2, OFF_DSPCR=3
  - ASCII_CR=7'h0D
  - DEFAULT_BASE=16'hD010
  - display state typedef {DSP_IDLE, DSP_BUSY}
- One sub-module, apple1_kbd_fifo: synchronous FIFO with push/pop/full/empty/head and a parameterised depth.

Test Plan:
1. Reset, then read $D011 and $D012 → 8'h00 and 8'h00; kbd_ready=1; dsp_valid=0.
2. Push kbd_data=8'h45 ('E') → $D011 reads 8'h80. Read $D010 → 8'hC5. The next $D011 read → 8'h00. A 3-cycle mem_read of $D010 pops only once.
3. Push 0x45, 0x30, 0x30, 0x30 and hold a 5th key (0x52) valid → kbd_ready=0 after the 4th push. Reads return C5, B0, B0, B0, D2 in order; the 5th key is accepted the cycle after the first pop.
4. With dsp_ready=0, write 8'h8D to $D012 → next cycle dsp_valid=1, dsp_data=7'h0D, and $D012 reads 8'h8D. Raise dsp_ready for 1 cycle → $D012 reads 8'h0D and dsp_valid=0.
5. While BUSY with dsp_data=7'h45, write 8'hB0 to $D012 → dsp_data stays 7'h45, dsp_overrun=1, and $D013 reads bit7=1. Write 8'hA7 to $D013 → it then reads 8'h27.
6. With UPCASE=1, push 8'h65 → $D010 reads 8'hC5. Push 2 keys, then pulse reset_n low mid-stream → $D011 reads 8'h00 and dsp_valid=0 immediately (asynchronous).
